// File: rtl/fetch_predict_unit.sv
// Fetch stage: PC register, next-PC selection and a direct-mapped BTB with
// 2-bit saturating counters, corrected by decode-stage branch resolution.
module fetch_predict_unit #(
    parameter int ADDR_W      = 6,
    parameter int BTB_ENTRIES = 8,
    parameter int RESET_PC    = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_f,
    output logic [ADDR_W-1:0] pc_f,
    output logic              pred_taken_f,
    output logic [ADDR_W-1:0] pred_target_f,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic              resolve_taken,
    input  logic [ADDR_W-1:0] resolve_target,
    input  logic              resolve_pred_taken,
    input  logic [ADDR_W-1:0] resolve_pred_target,
    output logic              flush_d,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int                IDX_W   = $clog2(BTB_ENTRIES);
    localparam int                TAG_W   = ADDR_W - IDX_W;
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]        btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0]  idx_f, idx_r;
    logic [TAG_W-1:0]  tag_f, tag_r;
    logic              hit_f, hit_r;
    logic              mispredict;
    logic [ADDR_W-1:0] pc_next;

    // Lookup reads pre-update contents; same-edge writes show up next cycle.
    always_comb begin
        idx_f = pc_f[IDX_W-1:0];
        tag_f = pc_f[ADDR_W-1:IDX_W];
        idx_r = resolve_pc[IDX_W-1:0];
        tag_r = resolve_pc[ADDR_W-1:IDX_W];
        hit_f = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
        hit_r = btb_valid[idx_r] && (btb_tag[idx_r] == tag_r);
        pred_taken_f  = hit_f && btb_ctr[idx_f][1];
        pred_target_f = pred_taken_f ? btb_target[idx_f] : pc_f + ADDR_W'(1);
    end

    always_comb begin
        mispredict = resolve_valid &&
                     ((resolve_taken != resolve_pred_taken) ||
                      (resolve_taken && resolve_pred_taken &&
                       (resolve_target != resolve_pred_target)));
        flush_d = mispredict && !reset;
    end

    // A redirect beats a hazard stall: the stalled fetch is on the wrong path.
    always_comb begin
        pc_next = pred_target_f;
        if (mispredict) begin
            pc_next = resolve_taken ? resolve_target : resolve_pc + ADDR_W'(1);
        end else if (stall_f) begin
            pc_next = pc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f             <= PC_RST;
            mispredict_count <= '0;
        end else begin
            pc_f <= pc_next;
            if (mispredict) begin
                mispredict_count <= cnt_sat_inc(mispredict_count);
            end
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so reset skips them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (resolve_valid) begin
            if (hit_r) begin
                if (resolve_taken) begin
                    btb_ctr[idx_r]    <= ctr_inc(btb_ctr[idx_r]);
                    btb_target[idx_r] <= resolve_target;
                end else begin
                    btb_ctr[idx_r] <= ctr_dec(btb_ctr[idx_r]);
                end
            end else if (resolve_taken) begin
                btb_valid[idx_r]  <= 1'b1;
                btb_tag[idx_r]    <= tag_r;
                btb_target[idx_r] <= resolve_target;
                btb_ctr[idx_r]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed scoreboard bench for fetch_predict_unit: per-cycle expectations are
// queued by the stimulus process and checked by an independent monitor.
module tb_fetch_predict_unit;

    logic       clk;
    logic       reset;
    logic       stall_f;
    logic [5:0] pc_f, pc_f_b;
    logic       pred_taken_f, pred_taken_f_b;
    logic [5:0] pred_target_f, pred_target_f_b;
    logic       resolve_valid;
    logic [5:0] resolve_pc;
    logic       resolve_taken;
    logic [5:0] resolve_target;
    logic       resolve_pred_taken;
    logic [5:0] resolve_pred_target;
    logic       flush_d, flush_d_b;
    logic [15:0] mispredict_count;
    logic [1:0]  mispredict_count_b;

    fetch_predict_unit #(.ADDR_W(6), .BTB_ENTRIES(8), .RESET_PC(0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall_f(stall_f),
        .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .flush_d(flush_d), .mispredict_count(mispredict_count)
    );

    // Same stimulus, 2-bit statistics counter to exercise saturation.
    fetch_predict_unit #(.ADDR_W(6), .BTB_ENTRIES(8), .RESET_PC(0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall_f(stall_f),
        .pc_f(pc_f_b), .pred_taken_f(pred_taken_f_b), .pred_target_f(pred_target_f_b),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .flush_d(flush_d_b), .mispredict_count(mispredict_count_b)
    );

    typedef struct {
        string name;
        int    pc;
        int    pt;
        int    tgt;
        int    fl;
        int    cnt;
        int    cnt2;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".pc_f"},          int'(pc_f),               e.pc);
            check({e.name, ".pred_taken_f"},  int'(pred_taken_f),       e.pt);
            check({e.name, ".pred_target_f"}, int'(pred_target_f),      e.tgt);
            check({e.name, ".flush_d"},       int'(flush_d),            e.fl);
            check({e.name, ".count"},         int'(mispredict_count),   e.cnt);
            check({e.name, ".count_sat"},     int'(mispredict_count_b), e.cnt2);
        end
    end

    // One cycle: drive inputs, queue the expected outputs for this cycle, advance.
    task automatic cyc(input string name, input bit rst, input bit st,
                       input bit rv, input int rpc, input bit rt, input int rtgt,
                       input bit rpt, input int rptgt,
                       input int e_pc, input int e_pt, input int e_tgt,
                       input int e_fl, input int e_cnt, input int e_cnt2);
        exp_t e;
        reset               = rst;
        stall_f             = st;
        resolve_valid       = rv;
        resolve_pc          = 6'(rpc);
        resolve_taken       = rt;
        resolve_target      = 6'(rtgt);
        resolve_pred_taken  = rpt;
        resolve_pred_target = 6'(rptgt);
        e.name = name; e.pc = e_pc; e.pt = e_pt; e.tgt = e_tgt;
        e.fl = e_fl; e.cnt = e_cnt; e.cnt2 = e_cnt2;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; resolve_valid = 1'b0; resolve_pc = '0;
        resolve_taken = 1'b0; resolve_target = '0; resolve_pred_taken = 1'b0;
        resolve_pred_target = '0;
        @(posedge clk);
        #1;
        //  name        rst st rv rpc T  tgt pT pTgt   pc pt tgt fl cnt c2
        cyc("reset",     1, 0, 0,  0, 0,  0, 0,  0,    0, 0,  1, 0, 0, 0);
        cyc("seq0",      0, 0, 0,  0, 0,  0, 0,  0,    0, 0,  1, 0, 0, 0);
        cyc("seq1",      0, 0, 0,  0, 0,  0, 0,  0,    1, 0,  2, 0, 0, 0);
        cyc("seq2",      0, 0, 0,  0, 0,  0, 0,  0,    2, 0,  3, 0, 0, 0);
        cyc("cold_br",   0, 0, 1,  5, 1, 20, 0,  0,    3, 0,  4, 1, 0, 0);
        cyc("redir20",   0, 0, 1,  4, 0,  0, 1,  9,   20, 0, 21, 1, 1, 1);
        cyc("hit5",      0, 1, 1,  5, 0,  0, 0,  0,    5, 1, 20, 0, 2, 2);
        cyc("ctr01",     0, 1, 1,  5, 1, 20, 1, 20,    5, 0,  6, 0, 2, 2);
        cyc("ctr10",     0, 1, 1,  5, 1, 20, 1, 20,    5, 1, 20, 0, 2, 2);
        cyc("ctr11",     0, 1, 1,  5, 0,  0, 0,  0,    5, 1, 20, 0, 2, 2);
        cyc("ctr10b",    0, 1, 0,  0, 0,  0, 0,  0,    5, 1, 20, 0, 2, 2);
        cyc("to13",      0, 0, 1,  2, 1, 13, 0,  0,    5, 1, 20, 1, 2, 2);
        cyc("alias13",   0, 0, 1, 13, 1,  2, 0,  0,   13, 0, 14, 1, 3, 3);
        cyc("hit2",      0, 0, 0,  0, 0,  0, 0,  0,    2, 1, 13, 0, 4, 3);
        cyc("hit13",     0, 0, 0,  0, 0,  0, 0,  0,   13, 1,  2, 0, 4, 3);
        cyc("nt_redir",  0, 0, 1,  3, 0,  0, 1,  4,    2, 1, 13, 1, 4, 3);
        cyc("pc4",       0, 0, 0,  0, 0,  0, 0,  0,    4, 0,  5, 0, 5, 3);
        cyc("miss5",     0, 0, 0,  0, 0,  0, 0,  0,    5, 0,  6, 0, 5, 3);
        cyc("pc6",       0, 0, 0,  0, 0,  0, 0,  0,    6, 0,  7, 0, 5, 3);
        cyc("stall1",    0, 1, 0,  0, 0,  0, 0,  0,    7, 0,  8, 0, 5, 3);
        cyc("stall2",    0, 1, 0,  0, 0,  0, 0,  0,    7, 0,  8, 0, 5, 3);
        cyc("stall3",    0, 1, 0,  0, 0,  0, 0,  0,    7, 0,  8, 0, 5, 3);
        cyc("stall_mis", 0, 1, 1,  9, 0,  0, 1, 10,    7, 0,  8, 1, 5, 3);
        cyc("rst_res",   1, 0, 1, 10, 1, 30, 0,  0,   10, 0, 11, 0, 6, 3);
        cyc("post_rst0", 0, 0, 0,  0, 0,  0, 0,  0,    0, 0,  1, 0, 0, 0);
        cyc("post_rst1", 0, 0, 0,  0, 0,  0, 0,  0,    1, 0,  2, 0, 0, 0);
        cyc("cleared2",  0, 0, 0,  0, 0,  0, 0,  0,    2, 0,  3, 0, 0, 0);
        cyc("to10",      0, 0, 1,  9, 0,  0, 1, 10,    3, 0,  4, 1, 0, 0);
        cyc("empty10",   0, 0, 1,  0, 1, 63, 0,  0,   10, 0, 11, 1, 1, 1);
        cyc("wrap63",    0, 0, 0,  0, 0,  0, 0,  0,   63, 0,  0, 0, 2, 2);
        cyc("bad_tgt",   0, 0, 1,  0, 1, 40, 1, 63,    0, 1, 63, 1, 2, 2);
        cyc("good_tgt",  0, 0, 1, 40, 1, 40, 1, 40,   40, 0, 41, 0, 3, 3);
        cyc("to40",      0, 0, 1, 39, 0,  0, 1, 40,   41, 0, 42, 1, 3, 3);
        cyc("hit40",     0, 0, 0,  0, 0,  0, 0,  0,   40, 1, 40, 0, 4, 3);
        resolve_valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
- Parametrised fetch stage for the pipelined core: PC register, next-PC selection, and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Replaces the fixed "PC+1 / decode-resolved branch / jump" muxing with predicted-taken fetch and decode-stage resolution feedback.
- Mispredicts redirect the PC and raise a flush for the fetch/decode pipeline register.
- Instruction memory stays external and is addressed by pc_f.

Parameters:
ADDR_W, 6, instruction address width (word-addressed PC)
BTB_ENTRIES, 8, number of BTB entries, power of 2, at least 2; IDX_W = log2(BTB_ENTRIES), IDX_W < ADDR_W
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of the mispredict statistics counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_f  in  1  hold PC (hazard stall from the hazard unit)
pc_f  out  ADDR_W  current fetch PC, drives instruction memory
pred_taken_f  out  1  BTB predicts taken for pc_f
pred_target_f  out  ADDR_W  predicted next PC for pc_f
resolve_valid  in  1  decode stage holds a resolved branch or jump this cycle
resolve_pc  in  ADDR_W  PC of the resolved instruction
resolve_taken  in  1  actual outcome; jumps are always 1
resolve_target  in  ADDR_W  actual taken target
resolve_pred_taken  in  1  prediction made when this instruction was fetched (piped through IF/ID)
resolve_pred_target  in  ADDR_W  predicted target carried with it
flush_d  out  1  mispredict; clear IF/ID register this cycle
mispredict_count  out  CNT_W  saturating count of mispredicts since reset

Behaviour:
- BTB entry fields: valid, tag = pc[ADDR_W-1:IDX_W], target[ADDR_W], ctr[2]. Index = pc[IDX_W-1:0].
- Counter encoding: 00 strongly not-taken (SNT), 01 weakly not-taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST). Predict taken when ctr[1] = 1.
- Lookup (combinational on pc_f):
  - hit = valid & tag match.
  - pred_taken_f = hit & ctr[1].
  - pred_target_f = stored target when pred_taken_f, else pc_f+1.
- PC arithmetic: pc+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- Mispredict (combinational) = resolve_valid & ((resolve_taken != resolve_pred_taken) | (resolve_taken & resolve_pred_taken & resolve_target != resolve_pred_target)).
- flush_d = mispredict; it is forced to 0 while reset = 1.
- Next PC, highest priority first:
  1. reset -> RESET_PC.
  2. mispredict -> resolve_taken ? resolve_target : resolve_pc+1. This overrides stall_f.
  3. stall_f -> hold pc_f.
  4. Otherwise -> pred_target_f.
- BTB update at the clock edge when resolve_valid = 1 and reset = 0; stall_f is ignored for updates.
  - Hit on resolve_pc, taken: ctr saturating increment; target <= resolve_target.
  - Hit on resolve_pc, not taken: ctr saturating decrement; target unchanged.
  - Miss, taken: allocate (overwrite) the entry: valid = 1, tag, target, ctr = 10.
  - Miss, not taken: no change.
- Same-cycle lookup and update of one entry: the lookup sees pre-update contents; the new contents are visible from the next cycle.
- mispredict_count increments by 1 per mispredict cycle and saturates at 2^CNT_W-1.
- Reset, including mid-operation:
  - All valid bits cleared; all ctr = 01.
  - pc_f = RESET_PC; mispredict_count = 0.
  - Reset overrides any concurrent resolve update.
  - Outputs in the first cycle after reset: pred_taken_f = 0, pred_target_f = RESET_PC+1, flush_d = 0 (when resolve_valid = 0).
- Timing: redirect latency is 1 cycle. The corrected PC appears on pc_f in the cycle after the mispredict.

Test Plan:
- Hold reset 2 cycles, then release with stall_f = 0 and no resolves -> pc_f = 0, 1, 2, 3 on successive cycles; pred_taken_f = 0; mispredict_count = 0.
- Cold taken branch: resolve_valid = 1, resolve_pc = 5, taken, target = 20, pred_taken = 0 -> flush_d = 1 that cycle; next pc_f = 20; mispredict_count = 1. A later fetch at pc_f = 5 gives pred_taken_f = 1, pred_target_f = 20.
- Counter hysteresis on entry 5 (ctr = 10):
  - One not-taken resolve -> ctr 01, prediction not-taken.
  - Two taken resolves -> ctr 11.
  - One not-taken resolve -> ctr 10, prediction still taken.
  - Correctly predicted resolves give flush_d = 0.
- Aliasing with BTB_ENTRIES = 8: entry holds pc 5. Fetch pc 13 -> miss, pred_taken_f = 0. Taken resolve at pc 13, target 2 -> entry replaced; pc 5 now misses.
- Stall vs redirect:
  - stall_f = 1 for 3 cycles at pc_f = 7 -> pc_f stays 7.
  - stall_f = 1 with a not-taken mispredict at resolve_pc = 9 -> next pc_f = 10.
  - Reset asserted in the same cycle as a taken resolve -> pc_f = 0 and the BTB is left empty.
- Wrap and saturation: pc_f = 63 with no hit -> next pc_f = 0. With CNT_W = 2, 5 mispredicts -> mispredict_count = 3.
